// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the access-legality and byte-enable helpers.
package lsu_pkg;

    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Misaligned halfword/word, reserved encodings, or unsigned-store forms.
    function automatic logic access_fault(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic       we);
        logic fault;
        case (f3)
            F3_B:    fault = 1'b0;
            F3_BU:   fault = we;
            F3_H:    fault = off[0];
            F3_HU:   fault = off[0] | we;
            F3_W:    fault = (off != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic       we);
        logic [3:0] be;
        if (!we) begin
            be = 4'b0000;
        end else begin
            case (f3)
                F3_B:    be = 4'b0001 << off;
                F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
                F3_W:    be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    import lsu_pkg::*;

    logic       mem_req;
    logic       mem_we;
    word_t      mem_addr;
    word_t      mem_wdata;
    logic [3:0] mem_be;
    logic       mem_ack;
    word_t      mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: replicates store data across lanes and extracts
// plus sign/zero-extends the addressed lane of a loaded word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0] st_funct3_i,
    input  word_t      st_data_i,
    input  logic [2:0] ld_funct3_i,
    input  logic [1:0] ld_off_i,
    input  word_t      ld_word_i,
    output word_t      st_word_o,
    output word_t      ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        st_word_o = st_data_i;
        case (st_funct3_i)
            F3_B, F3_BU: st_word_o = {4{st_data_i[7:0]}};
            F3_H, F3_HU: st_word_o = {2{st_data_i[15:0]}};
            default:     st_word_o = st_data_i;
        endcase
    end

    always_comb begin
        ld_byte = ld_word_i[7:0];
        case (ld_off_i)
            2'd0: ld_byte = ld_word_i[7:0];
            2'd1: ld_byte = ld_word_i[15:8];
            2'd2: ld_byte = ld_word_i[23:16];
            2'd3: ld_byte = ld_word_i[31:24];
            default: ld_byte = ld_word_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        ld_data_o = ld_word_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'd0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'd0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction from the core, runs a single
// bus transaction with timeout, and returns the extended load result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  word_t       addr,
    input  word_t       writeData,
    output word_t       readData,
    output logic        stall,
    output logic        addr_fault,
    output logic        bus_err,
    load_store_unit_if.master bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e state_q;
    logic [7:0] cnt_q;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic       we_q;
    logic       req_q;
    logic       bus_err_q;
    logic [3:0] be_q;
    word_t      addr_q;
    word_t      wdata_q;
    word_t      rdata_q;

    logic  idle_valid;
    logic  fault;
    word_t st_word;
    word_t ld_data;

    lsu_align u_align (
        .st_funct3_i (funct3),
        .st_data_i   (writeData),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_word_i   (bus.mem_rdata),
        .st_word_o   (st_word),
        .ld_data_o   (ld_data)
    );

    // Gated by reset_n so a held-high valid cannot stall or fault the core during reset.
    assign idle_valid = reset_n && (state_q == ST_IDLE) && valid;
    assign fault      = access_fault(funct3, addr[1:0], memWrite);
    assign addr_fault = idle_valid && fault;
    assign stall      = (idle_valid && !fault) || (state_q == ST_BUS);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            bus_err_q <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid && !fault) begin
                        addr_q  <= {addr[XLEN-1:2], 2'b00};
                        be_q    <= byte_enable(funct3, addr[1:0], memWrite);
                        wdata_q <= st_word;
                        f3_q    <= funct3;
                        off_q   <= addr[1:0];
                        we_q    <= memWrite;
                        req_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus.mem_ack) begin
                        if (!we_q) rdata_q <= ld_data;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        if (!we_q) rdata_q <= '0;
                        cnt_q     <= cnt_q + 8'd1;
                        bus_err_q <= 1'b1;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign readData      = rdata_q;
    assign bus_err       = bus_err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic        memWrite;
    logic [2:0]  funct3;
    word_t       addr;
    word_t       writeData;
    word_t       readData;
    logic        stall;
    logic        addr_fault;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .memWrite   (memWrite),
        .funct3     (funct3),
        .addr       (addr),
        .writeData  (writeData),
        .readData   (readData),
        .stall      (stall),
        .addr_fault (addr_fault),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one accepted access; returns in the DONE cycle with bus quiet.
    task automatic do_access(input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd,
                             output int stalls, output logic [31:0] c_addr,
                             output logic [31:0] c_wdata, output logic [3:0] c_be,
                             output logic c_we, output logic c_req);
        stalls = 0;
        valid = 1'b1; memWrite = we; funct3 = f3; addr = a; writeData = wd;
        #1;
        if (stall) stalls++;
        step();
        valid = 1'b0;
        c_addr = bus.mem_addr; c_wdata = bus.mem_wdata; c_be = bus.mem_be;
        c_we = bus.mem_we; c_req = bus.mem_req;
        for (int k = 0; k <= waits; k++) begin
            if (k == waits) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd;
            end
            #1;
            if (stall) stalls++;
            step();
        end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
    } fault_vec_t;

    fault_vec_t fv [8];

    initial begin
        int          stalls;
        int          n;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        logic        c_we, c_req;

        reset_n = 1'b0;
        valid = 1'b1; memWrite = 1'b0; funct3 = F3_W; addr = 32'h0; writeData = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        step();
        step();
        check("rst_stall", stall, 0);
        check("rst_fault", addr_fault, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_be", bus.mem_be, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_readData", readData, 0);
        check("rst_bus_err", bus_err, 0);
        valid = 1'b0;
        #3 reset_n = 1'b1;
        step();

        // SB at 0x1003, two wait cycles before ack
        do_access(1'b1, F3_B, 32'h1003, 32'h0000_00AB, 2, 32'h0,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("sb_req", c_req, 1);
        check("sb_we", c_we, 1);
        check("sb_addr", c_addr, 32'h1000);
        check("sb_be", c_be, 4'b1000);
        check("sb_wdata", c_wdata, 32'hABAB_ABAB);
        check("sb_stall_cycles", stalls, 4);
        check("sb_done_stall", stall, 0);
        check("sb_done_req", bus.mem_req, 0);
        check("sb_readData", readData, 0);
        step();

        // LB / LBU at 0x2001, lane 1 = 0xF0, same-cycle ack
        do_access(1'b0, F3_B, 32'h2001, 32'h0, 0, 32'h0000_F000,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("lb_addr", c_addr, 32'h2000);
        check("lb_be", c_be, 4'b0000);
        check("lb_we", c_we, 0);
        check("lb_stall_cycles", stalls, 2);
        check("lb_data", readData, 32'hFFFF_FFF0);
        step();
        do_access(1'b0, F3_BU, 32'h2001, 32'h0, 0, 32'h0000_F000,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("lbu_data", readData, 32'h0000_00F0);
        step();

        // LH at 0x2002 with ack on the last legal wait cycle
        do_access(1'b0, F3_H, 32'h2002, 32'h0, 3, 32'h8000_0000,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("lh_data", readData, 32'hFFFF_8000);
        check("lh_late_ack_no_err", bus_err, 0);
        check("lh_stall_cycles", stalls, 5);
        step();
        do_access(1'b0, F3_HU, 32'h2002, 32'h0, 1, 32'h8000_0000,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("lhu_data", readData, 32'h0000_8000);
        step();
        check("idle_hold_readData", readData, 32'h0000_8000);

        // Stores do not touch readData
        do_access(1'b1, F3_H, 32'h2002, 32'h0000_1234, 0, 32'hFFFF_FFFF,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("sh_be", c_be, 4'b1100);
        check("sh_wdata", c_wdata, 32'h1234_1234);
        check("sh_readData", readData, 32'h0000_8000);
        step();
        do_access(1'b1, F3_W, 32'h2000, 32'hDEAD_BEEF, 1, 32'h0,
                  stalls, c_addr, c_wdata, c_be, c_we, c_req);
        check("sw_be", c_be, 4'b1111);
        check("sw_wdata", c_wdata, 32'hDEAD_BEEF);
        step();

        // Stray ack in IDLE is ignored
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
        step();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        check("stray_ack_req", bus.mem_req, 0);
        check("stray_ack_readData", readData, 32'h0000_8000);

        // Illegal accesses: fault pulse, no bus activity
        fv[0] = '{1'b0, F3_W,   32'h2002};
        fv[1] = '{1'b0, F3_H,   32'h2001};
        fv[2] = '{1'b0, F3_HU,  32'h2003};
        fv[3] = '{1'b0, 3'b011, 32'h2000};
        fv[4] = '{1'b1, F3_BU,  32'h2000};
        fv[5] = '{1'b1, F3_HU,  32'h2000};
        fv[6] = '{1'b0, 3'b110, 32'h2000};
        fv[7] = '{1'b1, 3'b111, 32'h2000};
        foreach (fv[i]) begin
            valid = 1'b1; memWrite = fv[i].we; funct3 = fv[i].f3; addr = fv[i].a;
            #1;
            check($sformatf("fault%0d_pulse", i), addr_fault, 1);
            check($sformatf("fault%0d_stall", i), stall, 0);
            step();
            valid = 1'b0;
            #1;
            check($sformatf("fault%0d_req", i), bus.mem_req, 0);
            check($sformatf("fault%0d_clear", i), addr_fault, 0);
            step();
        end

        // LW timeout: TIMEOUT=4 BUS cycles, then bus_err in DONE
        valid = 1'b1; memWrite = 1'b0; funct3 = F3_W; addr = 32'h3000;
        step();
        valid = 1'b0;
        n = 0;
        while (bus.mem_req && n < 10) begin
            n++;
            step();
        end
        check("to_bus_cycles", n, 4);
        check("to_bus_err", bus_err, 1);
        check("to_readData", readData, 0);
        check("to_done_stall", stall, 0);
        step();
        check("to_bus_err_pulse", bus_err, 0);
        check("to_idle_req", bus.mem_req, 0);

        // Reset mid-BUS, then a late ack after release
        readData_probe: begin
            valid = 1'b1; memWrite = 1'b0; funct3 = F3_W; addr = 32'h4000;
            step();
            valid = 1'b0;
            check("rb_req_before", bus.mem_req, 1);
            reset_n = 1'b0;
            #1;
            check("rb_req_async", bus.mem_req, 0);
            check("rb_stall_async", stall, 0);
            step();
            #3 reset_n = 1'b1;
            step();
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
            #1;
            check("rb_late_stall", stall, 0);
            step();
            bus.mem_ack = 1'b0; bus.mem_rdata = '0;
            check("rb_late_req", bus.mem_req, 0);
            check("rb_late_readData", readData, 0);
            step();
            check("rb_idle_req", bus.mem_req, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: bus wait cycles before abort; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; the single clock.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 valid  input  1  core presents a memory instruction this cycle.
REQ-005 memWrite  input  1  1 = store, 0 = load; qualified by valid.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  `WORD  byte address (datapath ALUResult).
REQ-008 writeData  input  `WORD  store data, low-aligned.
REQ-009 readData  output  `WORD  extended load result to datapath write-back mux.
REQ-010 stall  output  1  freeze core PC/regfile write while high.
REQ-011 addr_fault  output  1  one-cycle pulse: misaligned address or illegal funct3.
REQ-012 bus_err  output  1  one-cycle pulse: bus timeout.
REQ-013 mem_req, mem_we  output  1 each  bus request / write strobe.
REQ-014 mem_addr  output  `WORD  word-aligned address, bits[1:0] = 00.
REQ-015 mem_wdata  output  `WORD; mem_be  output  4  lane-replicated store data / byte enables.
REQ-016 mem_ack  input  1; mem_rdata  input  `WORD  bus completion and load data.

Function
REQ-017 FSM states IDLE, BUS, DONE; reset state IDLE.
REQ-018 Fault check in IDLE when valid: H/HU with addr[0]=1, W with addr[1:0]!=00, funct3 in {011,110,111}, or store with funct3 in {100,101} -> addr_fault=1 that cycle, no bus access, stall=0, remain IDLE.
REQ-019 IDLE & valid & no fault -> register word address, be, replicated wdata, funct3, addr[1:0], memWrite; next state BUS; stall=1 that cycle.
REQ-020 Byte enables: B -> 0001<<addr[1:0]; H -> 0011 (addr[1]=0) or 1100; W -> 1111; mem_be=0000 for loads.
REQ-021 Store data: B -> byte replicated x4; H -> half replicated x2; W -> as-is.
REQ-022 BUS: mem_req=1, mem_we/mem_addr/mem_wdata/mem_be stable from registers; stall=1.
REQ-023 BUS & mem_ack -> on load, register readData = selected lane, sign-extended (B/H) or zero-extended (BU/HU); next DONE.
REQ-024 Timeout counter (8 bit) clears on BUS entry, increments per BUS cycle without ack; ack at count TIMEOUT-1 still wins; reaching TIMEOUT -> bus_err pulse, readData=0 on load, next DONE.
REQ-025 DONE: stall=0, mem_req=0 for exactly one cycle (core retires); valid ignored; next IDLE.
REQ-026 Minimum latency: 3 cycles accept-to-retire (IDLE, BUS with same-cycle ack, DONE).
REQ-027 mem_ack outside BUS is ignored; readData holds last load value until the next load completes; stores never modify readData.
REQ-028 stall = (IDLE & valid & no fault) | BUS, combinational.

Reset
REQ-029 reset_n low asynchronously forces IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, readData=0, timeout counter=0, addr_fault=0, bus_err=0, stall=0 (valid ignored until reset release).
REQ-030 Reset during BUS abandons the access; a late mem_ack after release has no effect.

Structure
REQ-031 Package lsu_pkg holds funct3 encodings, FSM state enum, and the byte-enable function.
REQ-032 One combinational sub-module lsu_align performs store lane replication and load lane extraction/extension.

Verification
REQ-033 SB addr=0x1003 data=0x000000AB, ack after 2 waits -> mem_addr=0x1000, be=1000, wdata=0xABABABAB, stall high 4 cycles.
REQ-034 LB addr=0x2001, mem_rdata=0x0000F000 -> readData=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-035 LH addr=0x2002, mem_rdata=0x80000000 -> readData=0xFFFF8000; LW addr=0x2002 -> addr_fault pulse, mem_req never asserted.
REQ-036 LW, TIMEOUT=4, ack never -> bus_err after 4 BUS cycles, readData=0, IDLE 2 cycles later.
REQ-037 reset_n low mid-BUS, then mem_ack pulse after release -> mem_req drops immediately, FSM stays IDLE, readData unchanged at 0.
